input_port_buffer: RTL

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

---
 rtl/noc_pkg.sv | 19 +
 rtl/input_port_buffer.sv | 93 +++++++++
 2 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: address width, default flit geometry and the
// helper that pulls the destination address out of a flit.
package noc_pkg;

  localparam int ADDR_W         = 8;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 4;

  // Widest flit the address helper accepts; narrower flits are zero-extended.
  localparam int FLIT_W_MAX = 256;

  // Destination address lives in the top ADDR_W bits of a data_w-bit flit
  // (x in the upper nibble, y in the lower nibble).
  function automatic logic [ADDR_W-1:0] flit_addr(input logic [FLIT_W_MAX-1:0] flit,
                                                  input int unsigned           data_w);
    return ADDR_W'(flit >> (data_w - ADDR_W));
  endfunction

endpackage

// File: rtl/input_port_buffer.sv
// Router input-port FIFO: circular buffer with first-word-fall-through head,
// back-pressure, and sticky overflow/underflow error flags.
module input_port_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  output logic                     buffer_full_o,
  output logic                     packet_valid_o,
  output logic [ADDR_W-1:0]        packet_addr_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     grant_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty, push, pop;
  logic [FLIT_W_MAX-1:0] head_ext;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop frees a slot in the same edge, so a full buffer still accepts a
  // write when it is also being drained (pass-through).
  assign pop   = grant_i & ~empty;
  assign push  = valid_i & (~full | pop);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d  = overflow_q | (valid_i & ~push);
    underflow_d = underflow_q | (grant_i & empty);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Control state register; reset clears occupancy so buffered flits are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flit storage; contents are intentionally left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Zero-extend the head flit so the shared address helper can decode it.
  always_comb begin
    head_ext               = '0;
    head_ext[DATA_W-1:0]   = mem_q[rd_ptr_q];
  end

  // Head is read combinationally from the read pointer: a written flit is
  // visible right after its write edge and holds until it is popped.
  assign data_o         = mem_q[rd_ptr_q];
  assign packet_addr_o  = flit_addr(head_ext, DATA_W);
  assign packet_valid_o = ~empty;
  assign buffer_full_o  = full;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
